// File: rtl/fifo_read_stage.sv
// Read side of a FIFO: issues reads, tracks RAM read latency and buffers returned words.
// Define FIFO_READ_STAGE_SKID_EN for a two-entry output buffer (head plus skid register).
module fifo_read_stage #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_read_req,
  input  logic [WIDTH-1:0] ram_read_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       buf_count
);

`ifdef FIFO_READ_STAGE_SKID_EN
  localparam logic [3:0] BUF_DEPTH = 4'd2;
`else
  localparam logic [3:0] BUF_DEPTH = 4'd1;
`endif

  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              valid_q;
  logic [WIDTH-1:0]  head_q, head_d;
  logic [3:0]        inflight_cnt;
  logic [3:0]        occupancy;
  logic              accept;
  logic              capture;
  logic              out_xfer;

  assign out_xfer = valid_q & out_ready;
  assign capture  = inflight_q[RD_LAT-1];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + {3'b000, inflight_q[i]};
    end
  end

  // A word draining this cycle frees its slot before any new read can land in it.
  assign occupancy     = {2'b00, count_q} + inflight_cnt - {3'b000, out_xfer};
  assign fifo_read_req = rst_n & ~fifo_empty & (occupancy < BUF_DEPTH);
  assign accept        = fifo_read_req & ~fifo_empty;

  always_comb begin
    inflight_d[0] = accept;
    for (int i = 1; i < RD_LAT; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  assign count_d = count_q + {1'b0, capture} - {1'b0, out_xfer};

`ifdef FIFO_READ_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       keep;

  // A capture lands in the first slot left free after this cycle's drain.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    keep   = count_q - {1'b0, out_xfer};
    if (out_xfer) begin
      head_d = skid_q;
    end
    if (capture) begin
      if (keep == 2'd0) begin
        head_d = ram_read_data;
      end else begin
        skid_d = ram_read_data;
      end
    end
  end

  // NOTE: skid_q is pure data qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end
`else
  always_comb begin
    head_d = head_q;
    if (capture) begin
      head_d = ram_read_data;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      count_q    <= 2'd0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      valid_q    <= (count_d != 2'd0);
      head_q     <= head_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign buf_count = count_q;

endmodule
